// File: rtl/frame_sequencer_if.sv
// Handshake bundle between the game engine, the frame sequencer and its three stage units.
interface frame_sequencer_if #(
  parameter int unsigned FCNT_W = 16
);
  logic              frame_tick;
  logic              pause;
  logic              clr_flags;
  logic              update_done;
  logic              collide_done;
  logic              render_done;
  logic              update_start;
  logic              collide_start;
  logic              render_start;
  logic              busy;
  logic [1:0]        stage;
  logic [FCNT_W-1:0] frame_count;
  logic              overrun;
  logic              timeout;

  modport master (
    output frame_tick, pause, clr_flags, update_done, collide_done, render_done,
    input  update_start, collide_start, render_start, busy, stage, frame_count,
           overrun, timeout
  );

  modport slave (
    input  frame_tick, pause, clr_flags, update_done, collide_done, render_done,
    output update_start, collide_start, render_start, busy, stage, frame_count,
           overrun, timeout
  );
endinterface

// File: rtl/frame_sequencer.sv
// Per-frame UPDATE -> COLLIDE -> RENDER sequencer with sticky overrun/timeout flags.
// Optional stage watchdog enabled by defining FRAME_SEQ_WATCHDOG_EN.
module frame_sequencer #(
  parameter int unsigned WDOG_CYCLES = 1024,
  parameter int unsigned FCNT_W      = 16
) (
  input logic              clk,
  input logic              rst,
  frame_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] UPDATE  = 2'd1;
  localparam logic [1:0] COLLIDE = 2'd2;
  localparam logic [1:0] RENDER  = 2'd3;

  if (WDOG_CYCLES < 2 || WDOG_CYCLES > 65535) begin : g_bad_wdog
    $error("frame_sequencer: WDOG_CYCLES must be within 2..65535");
  end

  logic [1:0]        state_q, state_d;
  logic              upd_start_q, upd_start_d;
  logic              col_start_q, col_start_d;
  logic              ren_start_q, ren_start_d;
  logic              busy_q, busy_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              overrun_q, overrun_d;
  logic              stage_done;

`ifdef FRAME_SEQ_WATCHDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timeout_q, timeout_d;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      upd_start_q <= 1'b0;
      col_start_q <= 1'b0;
      ren_start_q <= 1'b0;
      busy_q      <= 1'b0;
      fcnt_q      <= '0;
      overrun_q   <= 1'b0;
`ifdef FRAME_SEQ_WATCHDOG_EN
      wdog_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      upd_start_q <= upd_start_d;
      col_start_q <= col_start_d;
      ren_start_q <= ren_start_d;
      busy_q      <= busy_d;
      fcnt_q      <= fcnt_d;
      overrun_q   <= overrun_d;
`ifdef FRAME_SEQ_WATCHDOG_EN
      wdog_q      <= wdog_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    upd_start_d = 1'b0;
    col_start_d = 1'b0;
    ren_start_d = 1'b0;
    fcnt_d      = fcnt_q;
    overrun_d   = overrun_q & ~bus.clr_flags;
`ifdef FRAME_SEQ_WATCHDOG_EN
    timeout_d   = timeout_q & ~bus.clr_flags;
    wdog_d      = '0;
`endif

    // A done is honoured only from the current stage and never in its own start cycle
    stage_done = ((state_q == UPDATE)  && bus.update_done  && !upd_start_q) ||
                 ((state_q == COLLIDE) && bus.collide_done && !col_start_q) ||
                 ((state_q == RENDER)  && bus.render_done  && !ren_start_q);

    case (state_q)
      IDLE: begin
        if (bus.frame_tick && !bus.pause) begin
          state_d     = UPDATE;
          upd_start_d = 1'b1;
        end
      end
      UPDATE: begin
        if (stage_done) begin
          state_d     = COLLIDE;
          col_start_d = 1'b1;
        end
      end
      COLLIDE: begin
        if (stage_done) begin
          state_d     = RENDER;
          ren_start_d = 1'b1;
        end
      end
      RENDER: begin
        if (stage_done) begin
          state_d = IDLE;
          fcnt_d  = fcnt_q + FCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.frame_tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

`ifdef FRAME_SEQ_WATCHDOG_EN
    // Counter is zero in each start cycle; expiry abandons the frame uncounted
    if ((state_q != IDLE) && !stage_done) begin
      if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
        state_d   = IDLE;
        timeout_d = 1'b1;
      end else begin
        wdog_d = wdog_q + WDOG_W'(1);
      end
    end
`endif

    busy_d = (state_d != IDLE);
  end

  assign bus.update_start  = upd_start_q;
  assign bus.collide_start = col_start_q;
  assign bus.render_start  = ren_start_q;
  assign bus.busy          = busy_q;
  assign bus.stage         = state_q;
  assign bus.frame_count   = fcnt_q;
  assign bus.overrun       = overrun_q;
`ifdef FRAME_SEQ_WATCHDOG_EN
  assign bus.timeout       = timeout_q;
`else
  assign bus.timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: vector table, directed corner cases, random vs model.
module tb_frame_sequencer;
  localparam int unsigned FCNT_W      = 4;
  localparam int unsigned WDOG_CYCLES = 8;
`ifdef FRAME_SEQ_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  frame_sequencer_if #(.FCNT_W(FCNT_W)) bus ();

  frame_sequencer #(.WDOG_CYCLES(WDOG_CYCLES), .FCNT_W(FCNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: phase 0=idle,1..3=stage; age = cycles since the stage's start pulse
  int m_phase;
  int m_age;
  int m_fc;
  bit m_ovr;
  bit m_to;

  typedef struct {
    logic       tick, ud, cd, rd;
    logic       us, cs, rs, busy;
    logic [1:0] stage;
    int         fc;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_age   = 0;
    m_fc    = 0;
    m_ovr   = 1'b0;
    m_to    = 1'b0;
  endtask

  task automatic model_cycle(input bit tick, input bit pause, input bit clr,
                             input bit ud, input bit cd, input bit rd);
    bit done_ok, set_ovr, set_to;
    done_ok = (m_age > 0) && ((m_phase == 1 && ud) || (m_phase == 2 && cd) || (m_phase == 3 && rd));
    set_ovr = tick && (m_phase != 0);
    set_to  = 1'b0;
    if (m_phase == 0) begin
      if (tick && !pause) begin
        m_phase = 1;
        m_age   = 0;
      end
    end else if (done_ok) begin
      if (m_phase == 3) begin
        m_phase = 0;
        m_fc    = (m_fc + 1) % (1 << FCNT_W);
      end else begin
        m_phase = m_phase + 1;
        m_age   = 0;
      end
    end else if (WD_EN && (m_age == int'(WDOG_CYCLES) - 1)) begin
      m_phase = 0;
      set_to  = 1'b1;
    end else begin
      m_age = m_age + 1;
    end
    m_ovr = set_ovr || (m_ovr && !clr);
    m_to  = set_to  || (m_to  && !clr);
  endtask

  task automatic check_model();
    chk("model_update_start",  bus.update_start,  (m_phase == 1) && (m_age == 0));
    chk("model_collide_start", bus.collide_start, (m_phase == 2) && (m_age == 0));
    chk("model_render_start",  bus.render_start,  (m_phase == 3) && (m_age == 0));
    chk("model_busy",          bus.busy,          m_phase != 0);
    chk("model_stage",         bus.stage,         m_phase);
    chk("model_frame_count",   bus.frame_count,   m_fc);
    chk("model_overrun",       bus.overrun,       m_ovr);
    chk("model_timeout",       bus.timeout,       m_to);
    chk("one_hot_starts", 32'(bus.update_start) + 32'(bus.collide_start) + 32'(bus.render_start) <= 1, 1);
  endtask

  task automatic drive(input bit tick, input bit pause, input bit clr,
                       input bit ud, input bit cd, input bit rd);
    bus.frame_tick   = tick;
    bus.pause        = pause;
    bus.clr_flags    = clr;
    bus.update_done  = ud;
    bus.collide_done = cd;
    bus.render_done  = rd;
  endtask

  // Advance one clock; model consumes the inputs sampled at the edge, outputs checked 1ns later
  task automatic step();
    @(posedge clk);
    if (!rst) model_reset();
    else model_cycle(bus.frame_tick, bus.pause, bus.clr_flags,
                     bus.update_done, bus.collide_done, bus.render_done);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    model_reset();
    step();
    step();
    rst = 1'b1;
  endtask

  // Whole frame, each done one cycle after its stage's start
  task automatic run_frame();
    drive(1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    // Nominal frame, with stray done strobes that must be ignored
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1};

    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_stage", bus.stage, 0);
    chk("reset_frame_count", bus.frame_count, 0);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].tick, 0, 0, tbl[i].ud, tbl[i].cd, tbl[i].rd);
      step();
      chk($sformatf("tbl%0d_update_start", i),  bus.update_start,  tbl[i].us);
      chk($sformatf("tbl%0d_collide_start", i), bus.collide_start, tbl[i].cs);
      chk($sformatf("tbl%0d_render_start", i),  bus.render_start,  tbl[i].rs);
      chk($sformatf("tbl%0d_busy", i),          bus.busy,          tbl[i].busy);
      chk($sformatf("tbl%0d_stage", i),         bus.stage,         tbl[i].stage);
      chk($sformatf("tbl%0d_frame_count", i),   bus.frame_count,   tbl[i].fc);
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("post_frame_idle_busy", bus.busy, 0);

    // Overrun: tick two cycles into UPDATE
    do_reset();
    drive(1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0); step();
    chk("ovr_set", bus.overrun, 1);
    chk("ovr_no_restart", bus.update_start, 0);
    drive(0, 0, 0, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 1); step();
    chk("ovr_fc_once", bus.frame_count, 1);
    drive(0, 0, 0, 0, 0, 0); step();
    chk("ovr_stays_idle", bus.stage, 0);
    chk("ovr_fc_still", bus.frame_count, 1);
    drive(0, 0, 1, 0, 0, 0); step();
    chk("ovr_cleared", bus.overrun, 0);

    // Set beats clear; tick on the render_done-accept cycle is an overrun too
    drive(1, 0, 0, 0, 0, 0); step();
    drive(1, 0, 1, 0, 0, 0); step();
    chk("ovr_set_wins", bus.overrun, 1);
    drive(0, 0, 1, 0, 0, 0); step();
    chk("ovr_clr_busy", bus.overrun, 0);
    drive(0, 0, 0, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 1); step();
    chk("ovr_render_done_tick", bus.overrun, 1);
    chk("ovr_render_done_idle", bus.stage, 0);
    chk("ovr_render_done_fc", bus.frame_count, 2);
    drive(0, 0, 0, 0, 0, 0); step();
    chk("ovr_render_done_no_start", bus.update_start, 0);

    // Pause in IDLE drops ticks silently; pause mid-frame does not abort
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0, 0); step();
      chk("pause_no_start", bus.update_start, 0);
      chk("pause_idle", bus.stage, 0);
      chk("pause_no_overrun", bus.overrun, 0);
    end
    drive(1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 1, 0, 0); step();
    chk("pause_in_collide", bus.stage, 2);
    drive(0, 1, 0, 0, 0, 0); step();
    drive(0, 1, 0, 0, 1, 0); step();
    drive(0, 1, 0, 0, 0, 0); step();
    drive(0, 1, 0, 0, 0, 1); step();
    chk("pause_frame_done_fc", bus.frame_count, 1);
    chk("pause_frame_done_idle", bus.stage, 0);
    drive(0, 0, 0, 0, 0, 0);

    // Frame counter wrap at FCNT_W=4
    do_reset();
    for (int k = 0; k < 16; k++) begin
      run_frame();
      chk($sformatf("wrap_fc_%0d", k), bus.frame_count, (k + 1) % 16);
    end
    chk("wrap_to_zero", bus.frame_count, 0);

    // Withheld collide_done
    do_reset();
    drive(1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 1, 0, 0); step();
    chk("wd_collide_start", bus.collide_start, 1);
    drive(0, 0, 0, 0, 0, 0);
`ifdef FRAME_SEQ_WATCHDOG_EN
    for (int i = 0; i < 7; i++) step();
    chk("wd_still_collide", bus.stage, 2);
    chk("wd_not_yet", bus.timeout, 0);
    step();
    chk("wd_timeout", bus.timeout, 1);
    chk("wd_idle", bus.stage, 0);
    chk("wd_fc_unchanged", bus.frame_count, 0);
    drive(0, 0, 1, 0, 0, 0); step();
    chk("wd_clear", bus.timeout, 0);
    drive(0, 0, 0, 0, 0, 0);
`else
    for (int i = 0; i < 20; i++) step();
    chk("nowd_waits", bus.stage, 2);
    chk("nowd_timeout_zero", bus.timeout, 0);
    drive(0, 0, 0, 0, 1, 0); step();
    chk("nowd_render", bus.render_start, 1);
    drive(0, 0, 0, 0, 0, 0);
`endif

    // Asynchronous reset during RENDER
    do_reset();
    run_frame();
    drive(1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 0); step();
    chk("rst_pre_render", bus.render_start, 1);
    drive(0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_render_start", bus.render_start, 0);
    chk("rst_async_busy", bus.busy, 0);
    chk("rst_async_stage", bus.stage, 0);
    chk("rst_async_fc", bus.frame_count, 0);
    chk("rst_async_overrun", bus.overrun, 0);
    chk("rst_async_timeout", bus.timeout, 0);
    model_reset();
    step();
    rst = 1'b1;
    drive(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_needs_tick", bus.stage, 0);
    end

    // Random stimulus against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 The block SHALL have parameter WDOG_CYCLES, default 1024, setting stage watchdog limit in clk cycles (range 2..65535).
REQ-002 The block SHALL have parameter FCNT_W, default 16, setting the frame_count width.
REQ-003 The block SHALL have port clk, input, 1, sole clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port frame_tick, input, 1, one-cycle frame-advance strobe from the game engine.
REQ-006 The block SHALL have port pause, input, 1, level; when high, new frames are not started.
REQ-007 The block SHALL have port clr_flags, input, 1, one-cycle strobe clearing the sticky flags.
REQ-008 The block SHALL have ports update_done, collide_done, render_done, input, 1 each, completion strobes from the three stage units.
REQ-009 The block SHALL have ports update_start, collide_start, render_start, output, 1 each, one-cycle start pulses.
REQ-010 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-011 The block SHALL have port stage, output, 2, current state encoding: IDLE=0, UPDATE=1, COLLIDE=2, RENDER=3.
REQ-012 The block SHALL have port frame_count, output, FCNT_W, count of completed frames.
REQ-013 The block SHALL have ports overrun and timeout, output, 1 each, sticky error flags.

Function
REQ-014 The FSM SHALL leave IDLE only when frame_tick=1 and pause=0, entering UPDATE and asserting update_start in the first UPDATE cycle only.
REQ-015 Each stage SHALL wait for its done strobe, then advance UPDATE->COLLIDE->RENDER->IDLE, pulsing the next stage's start in its first cycle.
REQ-016 A done strobe in the same cycle as the stage's own start pulse SHALL be ignored; done strobes from stages other than the current one SHALL be ignored.
REQ-017 Stage-to-stage latency SHALL be exactly one cycle: done sampled high in cycle N gives the next start in cycle N+1.
REQ-018 frame_count SHALL increment by one on the RENDER->IDLE transition and wrap from all-ones to zero.
REQ-019 A frame_tick seen while state is not IDLE, including the cycle render_done is accepted, SHALL be dropped and SHALL set overrun.
REQ-020 A frame_tick seen in IDLE while pause=1 SHALL be dropped without setting overrun.
REQ-021 Asserting pause mid-frame SHALL NOT abort the frame; the frame SHALL finish normally.
REQ-022 clr_flags SHALL clear overrun and timeout; if a set condition occurs in the same cycle, set SHALL win.
REQ-023 Start pulses SHALL be registered outputs and at most one SHALL be high in any cycle.

Reset
REQ-024 On rst=0 the block SHALL asynchronously force IDLE, all start pulses 0, busy 0, stage 0, frame_count 0, overrun 0, timeout 0, watchdog counter 0.
REQ-025 Reset mid-frame SHALL abandon the frame without incrementing frame_count; the first post-reset frame SHALL need a fresh frame_tick.

Configuration
REQ-026 With macro FRAME_SEQ_WATCHDOG_EN defined, a per-stage counter SHALL clear on each start pulse; if the stage's done is not seen within WDOG_CYCLES cycles, the block SHALL set timeout, return to IDLE and not increment frame_count.
REQ-027 Without FRAME_SEQ_WATCHDOG_EN the watchdog logic SHALL be absent, stages SHALL wait indefinitely, and timeout SHALL be tied to 0.

Verification
REQ-028 Reset, tick, then each done 3 cycles after its start -> update/collide/render starts in cycles 1, 5, 9 after the tick; frame_count=1; busy low after render_done.
REQ-029 Second frame_tick 2 cycles into UPDATE -> overrun=1; frame_count increments once only; clr_flags -> overrun=0.
REQ-030 pause=1 with ticks in IDLE -> no starts, overrun=0; pause raised during COLLIDE -> frame completes, frame_count +1.
REQ-031 With FCNT_W=4, run 16 frames -> frame_count goes 15 to 0.
REQ-032 FRAME_SEQ_WATCHDOG_EN, WDOG_CYCLES=8, withhold collide_done -> timeout=1 after 8 cycles, state IDLE, frame_count unchanged.
REQ-033 rst=0 during RENDER -> all outputs at reset values immediately, before the next clk edge.
